rtc_bcd_clock: RTL and testbench

Parametrised real-time clock core that keeps BCD hours/minutes/seconds in 24-hour form and presents them on registered display outputs in 24-hour or 12-hour format. It adds run/pause, validated time loading, and a one-shot alarm compare. It sits between the system clock and the seven-segment scan driver, replacing the fixed 24-hour counter chain.

---
 rtl/rtc_bcd_clock.sv | 172 +++++++++++++++++
 tb/tb_rtc_bcd_clock.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bcd_clock.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | rtc_bcd_clock : BCD real-time clock with 12/24 h display, load, alarm   |
// | Revision 1.0                                                            |
// +-------------------------------------------------------------------------+
module rtc_bcd_clock #(
  parameter int TICK_DIV = 50_000_000,
  parameter int DIV_W    = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       mode_12h,
  input  logic       set_valid,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic [7:0] set_ss,
  input  logic       alarm_wr,
  input  logic [7:0] alarm_hh,
  input  logic [7:0] alarm_mm,
  input  logic       alarm_en,
  output logic [1:0] hh_t,
  output logic [3:0] hh_u,
  output logic [2:0] mm_t,
  output logic [3:0] mm_u,
  output logic [2:0] ss_t,
  output logic [3:0] ss_u,
  output logic       pm,
  output logic       sec_pulse,
  output logic       set_err,
  output logic       alarm_hit
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic [7:0]       cur_hh, cur_mm, cur_ss;
  logic [7:0]       al_hh, al_mm;
  logic             adv_d;

  logic [7:0] nxt_hh, nxt_mm, nxt_ss;
  logic [1:0] disp_t;
  logic [3:0] disp_u;
  logic       set_ok, alarm_ok, load, tick, advance;

  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
  endfunction

  assign set_ok   = bcd_ok(set_hh, 8'h23) && bcd_ok(set_mm, 8'h59) && bcd_ok(set_ss, 8'h59);
  assign alarm_ok = bcd_ok(alarm_hh, 8'h23) && bcd_ok(alarm_mm, 8'h59);
  assign load     = set_valid && set_ok;
  assign tick     = run && (div == DIV_LAST);
  // An accepted load swallows a coincident tick.
  assign advance  = tick && !load;

  always_comb begin
    nxt_hh = cur_hh;
    nxt_mm = cur_mm;
    nxt_ss = cur_ss;
    if (cur_ss[3:0] != 4'd9) begin
      nxt_ss[3:0] = cur_ss[3:0] + 4'd1;
    end else begin
      nxt_ss[3:0] = 4'd0;
      if (cur_ss[7:4] != 4'd5) begin
        nxt_ss[7:4] = cur_ss[7:4] + 4'd1;
      end else begin
        nxt_ss[7:4] = 4'd0;
        if (cur_mm[3:0] != 4'd9) begin
          nxt_mm[3:0] = cur_mm[3:0] + 4'd1;
        end else begin
          nxt_mm[3:0] = 4'd0;
          if (cur_mm[7:4] != 4'd5) begin
            nxt_mm[7:4] = cur_mm[7:4] + 4'd1;
          end else begin
            nxt_mm[7:4] = 4'd0;
            if (cur_hh == 8'h23)
              nxt_hh = 8'h00;
            else if (cur_hh[3:0] == 4'd9)
              nxt_hh = {cur_hh[7:4] + 4'd1, 4'd0};
            else
              nxt_hh[3:0] = cur_hh[3:0] + 4'd1;
          end
        end
      end
    end
  end

  // 12 h view: 00 -> 12, 13..19 -> 01..07, 20/21 -> 08/09, 22/23 -> 10/11.
  always_comb begin
    disp_t = cur_hh[5:4];
    disp_u = cur_hh[3:0];
    if (mode_12h) begin
      if (cur_hh == 8'h00) begin
        disp_t = 2'd1;
        disp_u = 4'd2;
      end else if (cur_hh > 8'h12) begin
        if (cur_hh[7:4] == 4'd1) begin
          disp_t = 2'd0;
          disp_u = cur_hh[3:0] - 4'd2;
        end else if (cur_hh[3:0] < 4'd2) begin
          disp_t = 2'd0;
          disp_u = cur_hh[3:0] + 4'd8;
        end else begin
          disp_t = 2'd1;
          disp_u = cur_hh[3:0] - 4'd2;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div       <= '0;
      cur_hh    <= 8'h00;
      cur_mm    <= 8'h00;
      cur_ss    <= 8'h00;
      al_hh     <= 8'h00;
      al_mm     <= 8'h00;
      adv_d     <= 1'b0;
      hh_t      <= '0;
      hh_u      <= '0;
      mm_t      <= '0;
      mm_u      <= '0;
      ss_t      <= '0;
      ss_u      <= '0;
      pm        <= 1'b0;
      sec_pulse <= 1'b0;
      set_err   <= 1'b0;
      alarm_hit <= 1'b0;
    end else begin
      if (load)
        div <= '0;
      else if (tick)
        div <= '0;
      else if (run)
        div <= div + DIV_W'(1);

      if (load) begin
        cur_hh <= set_hh;
        cur_mm <= set_mm;
        cur_ss <= set_ss;
      end else if (advance) begin
        cur_hh <= nxt_hh;
        cur_mm <= nxt_mm;
        cur_ss <= nxt_ss;
      end

      if (alarm_wr && alarm_ok) begin
        al_hh <= alarm_hh;
        al_mm <= alarm_mm;
      end

      // Pulses line up with the display refresh one cycle after the tick.
      adv_d     <= advance;
      sec_pulse <= adv_d;
      alarm_hit <= adv_d && alarm_en && (cur_hh == al_hh) && (cur_mm == al_mm)
                   && (cur_ss == 8'h00);
      set_err   <= (set_valid && !set_ok) || (alarm_wr && !alarm_ok);

      hh_t <= disp_t;
      hh_u <= disp_u;
      mm_t <= cur_mm[6:4];
      mm_u <= cur_mm[3:0];
      ss_t <= cur_ss[6:4];
      ss_u <= cur_ss[3:0];
      pm   <= mode_12h && (cur_hh >= 8'h12);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rtc_bcd_clock.sv
`default_nettype none
// Directed bench for rtc_bcd_clock with a 4-cycle second.
module tb_rtc_bcd_clock;

  localparam int TD = 4;
  localparam int DW = 3;

  logic       clk = 1'b0;
  logic       rst_n, run, mode_12h, set_valid, alarm_wr, alarm_en;
  logic [7:0] set_hh, set_mm, set_ss, alarm_hh, alarm_mm;
  logic [1:0] hh_t;
  logic [3:0] hh_u, mm_u, ss_u;
  logic [2:0] mm_t, ss_t;
  logic       pm, sec_pulse, set_err, alarm_hit;
  logic [23:0] shown;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_fail   = 0;

  rtc_bcd_clock #(.TICK_DIV(TD), .DIV_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .mode_12h(mode_12h),
    .set_valid(set_valid), .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
    .alarm_wr(alarm_wr), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_en(alarm_en),
    .hh_t(hh_t), .hh_u(hh_u), .mm_t(mm_t), .mm_u(mm_u), .ss_t(ss_t), .ss_u(ss_u),
    .pm(pm), .sec_pulse(sec_pulse), .set_err(set_err), .alarm_hit(alarm_hit)
  );

  always #5 clk = ~clk;

  assign shown = {2'b0, hh_t, hh_u, 1'b0, mm_t, mm_u, 1'b0, ss_t, ss_u};
  assign flags = {pm, sec_pulse, set_err, alarm_hit};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the bench just after the load edge.
  task automatic do_set(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    set_hh = h; set_mm = m; set_ss = s;
    set_valid = 1'b1;
    step(1);
    set_valid = 1'b0;
  endtask

  task automatic reject(input string tag, input logic [7:0] h, input logic [7:0] m,
                        input logic [7:0] s);
    do_set(8'h10, 8'h00, 8'h00);
    step(1);
    do_set(h, m, s);
    check({tag, "_err"}, set_err, 1);
    step(1);
    check({tag, "_err_clr"}, set_err, 0);
    check({tag, "_time"}, shown, 24'h100000);
  endtask

  task automatic alarm_write(input string tag, input logic [7:0] h, input logic [7:0] m,
                             input logic exp_err);
    alarm_hh = h; alarm_mm = m;
    alarm_wr = 1'b1;
    step(1);
    alarm_wr = 1'b0;
    check(tag, set_err, exp_err);
  endtask

  logic [15:0] pv;
  logic        seen;

  initial begin
    rst_n = 1'b0; run = 1'b0; mode_12h = 1'b1; set_valid = 1'b0; alarm_wr = 1'b0;
    alarm_en = 1'b0; set_hh = 0; set_mm = 0; set_ss = 0; alarm_hh = 0; alarm_mm = 0;
    step(2);
    check("rst_disp", shown, 24'h000000);
    check("rst_flags", flags, 4'b0000);

    // Free run from reset: ticks at edges 4, 8, 12, pulses one edge later.
    mode_12h = 1'b0;
    rst_n = 1'b1;
    run = 1'b1;
    pv = '0;
    for (int e = 1; e <= 13; e++) begin
      step(1);
      pv[e] = sec_pulse;
    end
    check("pulse_pattern", pv, 16'h2220);
    check("three_secs", shown, 24'h000003);

    // Midnight rollover; div is non-zero before the load, so pulse timing proves the restart.
    do_set(8'h23, 8'h59, 8'h58);
    step(1);
    check("load_disp", shown, 24'h235958);
    check("load_no_pulse", sec_pulse, 0);
    step(4);
    check("roll_a", shown, 24'h235959);
    check("roll_a_pulse", sec_pulse, 1);
    step(4);
    check("roll_b", shown, 24'h000000);
    check("roll_b_pulse", sec_pulse, 1);

    // 12 h conversion.
    mode_12h = 1'b1;
    do_set(8'h00, 8'h30, 8'h00); step(1);
    check("h12_00", shown, 24'h123000); check("h12_00_pm", pm, 0);
    do_set(8'h12, 8'h00, 8'h00); step(1);
    check("h12_12", shown, 24'h120000); check("h12_12_pm", pm, 1);
    do_set(8'h13, 8'h05, 8'h00); step(1);
    check("h12_13", shown, 24'h010500); check("h12_13_pm", pm, 1);
    do_set(8'h11, 8'h59, 8'h00); step(1);
    check("h12_11", shown, 24'h115900); check("h12_11_pm", pm, 0);
    do_set(8'h20, 8'h00, 8'h00); step(1);
    check("h12_20", shown, 24'h080000); check("h12_20_pm", pm, 1);
    do_set(8'h23, 8'h00, 8'h00); step(1);
    check("h12_23", shown, 24'h110000); check("h12_23_pm", pm, 1);
    mode_12h = 1'b0;
    step(1);
    check("h24_back", shown, 24'h230000); check("h24_back_pm", pm, 0);

    // Rejected loads.
    reject("bad_hh", 8'h24, 8'h00, 8'h00);
    reject("bad_mm", 8'h10, 8'h5A, 8'h00);
    reject("bad_ss", 8'h10, 8'h00, 8'h60);

    // Load on the same edge as a tick.
    do_set(8'h01, 8'h02, 8'h03);
    step(3);
    do_set(8'h10, 8'h20, 8'h30);
    step(1);
    check("coinc_disp", shown, 24'h102030);
    check("coinc_no_pulse", sec_pulse, 0);
    step(3);
    check("coinc_hold", shown, 24'h102030);
    step(1);
    check("coinc_next", shown, 24'h102031);
    check("coinc_pulse", sec_pulse, 1);

    // Alarm.
    alarm_write("al_ok", 8'h07, 8'h00, 1'b0);
    alarm_write("al_bad_hh", 8'h24, 8'h00, 1'b1);
    alarm_write("al_bad_mm", 8'h07, 8'h60, 1'b1);
    alarm_en = 1'b1;
    do_set(8'h06, 8'h59, 8'h59);
    step(4);
    check("al_early", alarm_hit, 0);
    step(1);
    check("al_disp", shown, 24'h070000);
    check("al_hit", alarm_hit, 1);
    step(1);
    check("al_one_shot", alarm_hit, 0);
    do_set(8'h07, 8'h00, 8'h00);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      seen |= alarm_hit;
    end
    check("al_no_load_hit", seen, 0);
    check("al_after_load", shown, 24'h070001);
    alarm_en = 1'b0;

    // Pause mid-second with div at 2.
    do_set(8'h00, 8'h00, 8'h00);
    step(2);
    run = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      seen |= sec_pulse;
    end
    check("pause_no_pulse", seen, 0);
    check("pause_disp", shown, 24'h000000);
    run = 1'b1;
    step(2);
    check("resume_hold", shown, 24'h000000);
    step(1);
    check("resume_tick", shown, 24'h000001);
    check("resume_pulse", sec_pulse, 1);

    // Asynchronous reset mid-count.
    mode_12h = 1'b1;
    do_set(8'h13, 8'h45, 8'h12);
    step(1);
    check("pre_rst_disp", shown, 24'h014512);
    check("pre_rst_pm", pm, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_disp", shown, 24'h000000);
    check("async_rst_flags", flags, 4'b0000);

    // Alarm registers come out of reset as 00:00.
    step(1);
    rst_n = 1'b1;
    mode_12h = 1'b0;
    alarm_en = 1'b1;
    do_set(8'h23, 8'h59, 8'h59);
    step(5);
    check("rst_alarm_disp", shown, 24'h000000);
    check("rst_alarm_hit", alarm_hit, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
